// File: rtl/parking_sensor_decoder.sv
// Parking-gate sensor decoder: synchronises and filters the two beam sensors,
// then tracks entry/exit direction to emit single-cycle up/down/error pulses.
module parking_sensor_decoder #(
  parameter int unsigned FILTER_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic up,
  output logic down,
  output logic error,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    EN1,
    EN2,
    EN3,
    EX1,
    EX2,
    EX3,
    RESYNC
  } state_t;

  localparam logic [3:0] FC = 4'(FILTER_CYCLES);

  logic [1:0] a_sync;
  logic [1:0] b_sync;
  logic [1:0] s;
  logic [1:0] s_q;
  logic [1:0] f;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  state_t     state;

  assign s    = {a_sync[1], b_sync[1]};
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[0], a};
      b_sync <= {b_sync[0], b};
    end
  end

  // A changed candidate restarts the run; a steady one extends it.
  always_comb begin
    cnt_nx = cnt + 4'd1;
    if (s != s_q) cnt_nx = 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
      f   <= '0;
      cnt <= '0;
    end else begin
      s_q <= s;
      if (s == f) begin
        cnt <= '0;
      end else if (cnt_nx >= FC) begin
        f   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      up    <= 1'b0;
      down  <= 1'b0;
      error <= 1'b0;
    end else begin
      up    <= 1'b0;
      down  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          case (f)
            2'b10: state <= EN1;
            2'b01: state <= EX1;
            2'b11: begin
              error <= 1'b1;
              state <= RESYNC;
            end
            default: ;
          endcase
        end
        EN1: begin
          case (f)
            2'b11: state <= EN2;
            2'b00: state <= IDLE;
            2'b01: begin
              error <= 1'b1;
              state <= RESYNC;
            end
            default: ;
          endcase
        end
        EN2: begin
          case (f)
            2'b01: state <= EN3;
            2'b10: state <= EN1;
            2'b00: begin
              error <= 1'b1;
              state <= RESYNC;
            end
            default: ;
          endcase
        end
        EN3: begin
          case (f)
            2'b00: begin
              up    <= 1'b1;
              state <= IDLE;
            end
            2'b11: state <= EN2;
            2'b10: begin
              error <= 1'b1;
              state <= RESYNC;
            end
            default: ;
          endcase
        end
        EX1: begin
          case (f)
            2'b11: state <= EX2;
            2'b00: state <= IDLE;
            2'b10: begin
              error <= 1'b1;
              state <= RESYNC;
            end
            default: ;
          endcase
        end
        EX2: begin
          case (f)
            2'b10: state <= EX3;
            2'b01: state <= EX1;
            2'b00: begin
              error <= 1'b1;
              state <= RESYNC;
            end
            default: ;
          endcase
        end
        EX3: begin
          case (f)
            2'b00: begin
              down  <= 1'b1;
              state <= IDLE;
            end
            2'b11: state <= EX2;
            2'b01: begin
              error <= 1'b1;
              state <= RESYNC;
            end
            default: ;
          endcase
        end
        RESYNC: begin
          if (f == 2'b00) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_sensor_decoder.sv
// Directed bench for parking_sensor_decoder: table of held sensor levels
// with expected pulse counts, plus hand sequences for timing corners.
module tb_parking_sensor_decoder;

  typedef struct {
    logic [1:0] ab;
    int         eu;
    int         ed;
    int         ee;
    logic       eb;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic a;
  logic b;
  logic up;
  logic down;
  logic error;
  logic busy;

  int checks = 0;
  int errors = 0;
  int upc;
  int dnc;
  int erc;
  bit busy_seen;
  vec_t tbl[$];

  parking_sensor_decoder #(.FILTER_CYCLES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .a    (a),
    .b    (b),
    .up   (up),
    .down (down),
    .error(error),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      upc += int'(up);
      dnc += int'(down);
      erc += int'(error);
      if (busy) busy_seen = 1'b1;
      if (int'(up) + int'(down) + int'(error) > 1) begin
        errors++;
        $display("FAIL onehot up=%0b down=%0b error=%0b", up, down, error);
      end
    end
  end

  task automatic clr();
    upc = 0;
    dnc = 0;
    erc = 0;
    busy_seen = 1'b0;
  endtask

  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic apply(input logic [1:0] ab, input int n);
    a = ab[1];
    b = ab[0];
    clr();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic vec_t mk(logic [1:0] ab, int eu, int ed, int ee,
                              logic eb);
    vec_t v;
    v.ab = ab;
    v.eu = eu;
    v.ed = ed;
    v.ee = ee;
    v.eb = eb;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int first;
    logic b4;
    logic b5;

    // entry
    tbl.push_back(mk(2'b00, 0, 0, 0, 1'b0));
    tbl.push_back(mk(2'b10, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b11, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b01, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b00, 1, 0, 0, 1'b0));
    // exit
    tbl.push_back(mk(2'b01, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b11, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b10, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b00, 0, 1, 0, 1'b0));
    // abort and back-off
    tbl.push_back(mk(2'b10, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b11, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b10, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1'b0));
    tbl.push_back(mk(2'b10, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b11, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b01, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b11, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b10, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1'b0));
    // illegal jump from idle, then no down out of resync
    tbl.push_back(mk(2'b11, 0, 0, 1, 1'b1));
    tbl.push_back(mk(2'b01, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1'b0));
    // EN2 sees 00
    tbl.push_back(mk(2'b10, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b11, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b00, 0, 0, 1, 1'b0));
    // EN3 sees 10
    tbl.push_back(mk(2'b10, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b11, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b01, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b10, 0, 0, 1, 1'b1));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1'b0));
    // EX1 sees 10, EN1 sees 01
    tbl.push_back(mk(2'b01, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b10, 0, 0, 1, 1'b1));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1'b0));
    tbl.push_back(mk(2'b10, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b01, 0, 0, 1, 1'b1));
    tbl.push_back(mk(2'b00, 0, 0, 0, 1'b0));
    // EX2 sees 00
    tbl.push_back(mk(2'b01, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b11, 0, 0, 0, 1'b1));
    tbl.push_back(mk(2'b00, 0, 0, 1, 1'b0));

    reset = 1'b1;
    a = 1'b0;
    b = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.up", int'(up), 0);
    chk("rst.down", int'(down), 0);
    chk("rst.error", int'(error), 0);
    chk("rst.busy", int'(busy), 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      apply(tbl[i].ab, 6);
      chk($sformatf("v%0d.up", i), upc, tbl[i].eu);
      chk($sformatf("v%0d.down", i), dnc, tbl[i].ed);
      chk($sformatf("v%0d.error", i), erc, tbl[i].ee);
      chk($sformatf("v%0d.busy", i), int'(busy), int'(tbl[i].eb));
    end

    // up latency: final 00 first sampled at edge 1, up seen after edge 5
    apply(2'b10, 6);
    apply(2'b11, 6);
    apply(2'b01, 6);
    a = 1'b0;
    b = 1'b0;
    clr();
    first = 0;
    b4 = 1'b0;
    b5 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (up && first == 0) first = i;
      if (i == 4) b4 = busy;
      if (i == 5) b5 = busy;
    end
    chk("lat.edge", first, 5);
    chk("lat.busy_before", int'(b4), 1);
    chk("lat.busy_after", int'(b5), 0);
    chk("lat.count", upc, 1);

    // one-cycle glitch on a is rejected
    a = 1'b1;
    clr();
    @(posedge clk);
    #1;
    a = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("glitch1.busy_seen", int'(busy_seen), 0);

    // three-cycle pulse on a is accepted then aborted
    a = 1'b1;
    clr();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    a = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("glitch3.busy_seen", int'(busy_seen), 1);
    chk("glitch3.up", upc, 0);
    chk("glitch3.error", erc, 0);
    chk("glitch3.busy", int'(busy), 0);

    // reset while in EN2
    apply(2'b10, 6);
    apply(2'b11, 6);
    chk("mid.busy_pre", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid.busy_async", int'(busy), 0);
    chk("mid.up_async", int'(up), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clr();
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("mid.error", erc, 1);
    chk("mid.up", upc, 0);
    chk("mid.busy_resync", int'(busy), 1);
    apply(2'b00, 6);
    chk("mid.busy_idle", int'(busy), 0);
    chk("mid.up_after", upc, 0);
    chk("mid.error_after", erc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
